// File: rtl/adrv9001_tdd_enable_sequencer.sv
// Per-channel TDD sequencer for the ADRV9001 rx/tx enable pins and FPGA datapath gates.
// Guard, setup and hold timing keep RX and TX from ever being enabled together.
`timescale 1ns/1ps
module adrv9001_tdd_enable_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             rx_auto,
    input  logic             tx_req,
    input  logic             tx_done,
    input  logic [CNT_W-1:0] guard_cycles,
    input  logic [CNT_W-1:0] rx_setup_cycles,
    input  logic [CNT_W-1:0] tx_setup_cycles,
    input  logic [CNT_W-1:0] tx_hold_cycles,
    output logic             tx_ack,
    output logic             rx_gate,
    output logic             tx_gate,
    output logic             adrv9001_rx_en,
    output logic             adrv9001_tx_en,
    output logic             busy,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_SETUP = 3'd1,
        RX       = 3'd2,
        GUARD_RT = 3'd3,
        TX_SETUP = 3'd4,
        TX       = 3'd5,
        TX_HOLD  = 3'd6,
        GUARD_TR = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired;
    logic             tx_ack_q, tx_ack_d;
    logic             rx_gate_q, tx_gate_q, rx_en_q, tx_en_q, busy_q;

    // Counter holds remaining cycles minus one, so a count of 0 still lasts one cycle.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    assign expired = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = expired ? cnt_q : cnt_q - CNT_W'(1);
        tx_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && tx_req) begin
                    state_d = GUARD_RT;
                    cnt_d   = load_cnt(guard_cycles);
                end else if (enable && rx_auto) begin
                    state_d = RX_SETUP;
                    cnt_d   = load_cnt(rx_setup_cycles);
                end
            end
            RX_SETUP: begin
                // Aborts win over expiry so a pending TX request never passes through RX.
                if (!enable || tx_req) begin
                    if (enable && tx_req) begin
                        state_d = GUARD_RT;
                        cnt_d   = load_cnt(guard_cycles);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (expired) begin
                    state_d = RX;
                end
            end
            RX: begin
                if (enable && tx_req) begin
                    state_d = GUARD_RT;
                    cnt_d   = load_cnt(guard_cycles);
                end else if (!enable || !rx_auto) begin
                    state_d = IDLE;
                end
            end
            GUARD_RT: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = TX_SETUP;
                    cnt_d   = load_cnt(tx_setup_cycles);
                end
            end
            TX_SETUP: begin
                if (!enable) begin
                    state_d = TX_HOLD;
                    cnt_d   = load_cnt(tx_hold_cycles);
                end else if (expired) begin
                    state_d  = TX;
                    tx_ack_d = 1'b1;
                end
            end
            TX: begin
                if (tx_done || !enable) begin
                    state_d = TX_HOLD;
                    cnt_d   = load_cnt(tx_hold_cycles);
                end
            end
            TX_HOLD: begin
                if (expired) begin
                    state_d = GUARD_TR;
                    cnt_d   = load_cnt(guard_cycles);
                end
            end
            GUARD_TR: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (expired) begin
                    if (rx_auto) begin
                        state_d = RX_SETUP;
                        cnt_d   = load_cnt(rx_setup_cycles);
                    end else if (tx_req) begin
                        state_d = GUARD_RT;
                        cnt_d   = load_cnt(guard_cycles);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_ack_q  <= 1'b0;
            rx_gate_q <= 1'b0;
            tx_gate_q <= 1'b0;
            rx_en_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_ack_q  <= tx_ack_d;
            rx_gate_q <= (state_d == RX);
            tx_gate_q <= (state_d == TX);
            rx_en_q   <= (state_d == RX_SETUP) || (state_d == RX);
            tx_en_q   <= (state_d == TX_SETUP) || (state_d == TX) || (state_d == TX_HOLD);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign tx_ack         = tx_ack_q;
    assign rx_gate        = rx_gate_q;
    assign tx_gate        = tx_gate_q;
    assign adrv9001_rx_en = rx_en_q;
    assign adrv9001_tx_en = tx_en_q;
    assign busy           = busy_q;
    assign state          = state_q;

endmodule

// File: tb/tb_adrv9001_tdd_enable_sequencer.sv
// Directed bench for adrv9001_tdd_enable_sequencer with a per-cycle rx/tx exclusion check.
// Output vectors are {state[2:0], busy, rx_en, tx_en, rx_gate, tx_gate, tx_ack}.
`timescale 1ns/1ps
module tb_adrv9001_tdd_enable_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             enable, rx_auto, tx_req, tx_done;
    logic [CNT_W-1:0] guard_cycles, rx_setup_cycles, tx_setup_cycles, tx_hold_cycles;
    logic             tx_ack, rx_gate, tx_gate, adrv9001_rx_en, adrv9001_tx_en, busy;
    logic [2:0]       state;

    int checks   = 0;
    int failures = 0;
    logic prev_rx = 1'b0;
    logic prev_tx = 1'b0;

    adrv9001_tdd_enable_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .rx_auto(rx_auto),
        .tx_req(tx_req), .tx_done(tx_done),
        .guard_cycles(guard_cycles), .rx_setup_cycles(rx_setup_cycles),
        .tx_setup_cycles(tx_setup_cycles), .tx_hold_cycles(tx_hold_cycles),
        .tx_ack(tx_ack), .rx_gate(rx_gate), .tx_gate(tx_gate),
        .adrv9001_rx_en(adrv9001_rx_en), .adrv9001_tx_en(adrv9001_tx_en),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {state, busy, adrv9001_rx_en, adrv9001_tx_en, rx_gate, tx_gate, tx_ack};
    endfunction

    // Advance one clock and sample 1ns later; enforces rx/tx exclusion and guard adjacency.
    task automatic step();
        @(posedge clk);
        #1;
        checks++;
        if (rstn && ((adrv9001_rx_en && adrv9001_tx_en) || (prev_rx && adrv9001_tx_en) ||
                     (prev_tx && adrv9001_rx_en))) begin
            failures++;
            $display("FAIL invariant rx_en=%0b tx_en=%0b prev_rx=%0b prev_tx=%0b required no overlap/adjacency",
                     adrv9001_rx_en, adrv9001_tx_en, prev_rx, prev_tx);
        end
        prev_rx = adrv9001_rx_en;
        prev_tx = adrv9001_tx_en;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        enable = 1'b0; rx_auto = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        guard_cycles = '0; rx_setup_cycles = '0; tx_setup_cycles = '0; tx_hold_cycles = '0;
        repeat (2) step();
        rstn = 1'b1;
        prev_rx = 1'b0;
        prev_tx = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", outs(), 9'b000_000000);
        end
        step();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL reset_idle_hold got=%b exp=%b", outs(), 9'b000_000000);
        end
    endtask

    // rx_setup=4: rx_en one cycle after enable, rx_gate four cycles after rx_en.
    task automatic test_rx_setup();
        rx_setup_cycles = 16'd4;
        enable = 1'b1; rx_auto = 1'b1;
        step();
        checks++;
        if (outs() !== {3'd1, 6'b110000}) begin
            failures++; $display("FAIL rx_setup_entry got=%b exp=%b", outs(), {3'd1, 6'b110000});
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (outs() !== {3'd1, 6'b110000}) begin
                failures++; $display("FAIL rx_setup_wait%0d got=%b exp=%b", i, outs(), {3'd1, 6'b110000});
            end
        end
        step();
        checks++;
        if (outs() !== {3'd2, 6'b110100}) begin
            failures++; $display("FAIL rx_gate_on got=%b exp=%b", outs(), {3'd2, 6'b110100});
        end
    endtask

    // RX -> TX with guard=3, tx_setup=2.
    task automatic test_rx_to_tx();
        guard_cycles = 16'd3; tx_setup_cycles = 16'd2;
        tx_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== {3'd3, 6'b100000}) begin
                failures++; $display("FAIL rt_guard%0d got=%b exp=%b", i, outs(), {3'd3, 6'b100000});
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs() !== {3'd4, 6'b101000}) begin
                failures++; $display("FAIL tx_setup%0d got=%b exp=%b", i, outs(), {3'd4, 6'b101000});
            end
        end
        step();
        checks++;
        if (outs() !== {3'd5, 6'b101011}) begin
            failures++; $display("FAIL tx_entry_ack got=%b exp=%b", outs(), {3'd5, 6'b101011});
        end
        step();
        checks++;
        if (outs() !== {3'd5, 6'b101010}) begin
            failures++; $display("FAIL tx_ack_single got=%b exp=%b", outs(), {3'd5, 6'b101010});
        end
        tx_req = 1'b0;
    endtask

    // TX end: hold=5, guard=2, rx_auto=1 -> back to RX_SETUP.
    task automatic test_tx_to_rx();
        tx_hold_cycles = 16'd5; guard_cycles = 16'd2;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (outs() !== {3'd6, 6'b101000}) begin
            failures++; $display("FAIL tx_hold_entry got=%b exp=%b", outs(), {3'd6, 6'b101000});
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (outs() !== {3'd6, 6'b101000}) begin
                failures++; $display("FAIL tx_hold%0d got=%b exp=%b", i, outs(), {3'd6, 6'b101000});
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs() !== {3'd7, 6'b100000}) begin
                failures++; $display("FAIL tr_guard%0d got=%b exp=%b", i, outs(), {3'd7, 6'b100000});
            end
        end
        step();
        checks++;
        if (outs() !== {3'd1, 6'b110000}) begin
            failures++; $display("FAIL tr_to_rx_setup got=%b exp=%b", outs(), {3'd1, 6'b110000});
        end
        enable = 1'b0;
        step();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL disable_to_idle got=%b exp=%b", outs(), 9'b000_000000);
        end
    endtask

    // All counts zero, then tx_req held across a burst with rx_auto low.
    task automatic test_back_to_back();
        guard_cycles = '0; rx_setup_cycles = '0; tx_setup_cycles = '0; tx_hold_cycles = '0;
        enable = 1'b1; rx_auto = 1'b1;
        step();
        checks++;
        if (outs() !== {3'd1, 6'b110000}) begin
            failures++; $display("FAIL z_rx_setup got=%b exp=%b", outs(), {3'd1, 6'b110000});
        end
        step();
        checks++;
        if (outs() !== {3'd2, 6'b110100}) begin
            failures++; $display("FAIL z_rx got=%b exp=%b", outs(), {3'd2, 6'b110100});
        end
        tx_req = 1'b1;
        step();
        checks++;
        if (outs() !== {3'd3, 6'b100000}) begin
            failures++; $display("FAIL z_guard got=%b exp=%b", outs(), {3'd3, 6'b100000});
        end
        step();
        checks++;
        if (outs() !== {3'd4, 6'b101000}) begin
            failures++; $display("FAIL z_tx_setup got=%b exp=%b", outs(), {3'd4, 6'b101000});
        end
        step();
        checks++;
        if (outs() !== {3'd5, 6'b101011}) begin
            failures++; $display("FAIL z_tx_3cyc got=%b exp=%b", outs(), {3'd5, 6'b101011});
        end
        rx_auto = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (outs() !== {3'd6, 6'b101000}) begin
            failures++; $display("FAIL z_hold got=%b exp=%b", outs(), {3'd6, 6'b101000});
        end
        step();
        checks++;
        if (outs() !== {3'd7, 6'b100000}) begin
            failures++; $display("FAIL z_guard_tr got=%b exp=%b", outs(), {3'd7, 6'b100000});
        end
        step();
        checks++;
        if (outs() !== {3'd3, 6'b100000}) begin
            failures++; $display("FAIL b2b_reburst got=%b exp=%b", outs(), {3'd3, 6'b100000});
        end
        step();
        step();
        checks++;
        if (outs() !== {3'd5, 6'b101011}) begin
            failures++; $display("FAIL b2b_tx got=%b exp=%b", outs(), {3'd5, 6'b101011});
        end
        tx_req = 1'b0;
        enable = 1'b0;
        step();
        checks++;
        if (outs() !== {3'd6, 6'b101000}) begin
            failures++; $display("FAIL dis_tx_hold got=%b exp=%b", outs(), {3'd6, 6'b101000});
        end
        step();
        checks++;
        if (outs() !== {3'd7, 6'b100000}) begin
            failures++; $display("FAIL dis_guard got=%b exp=%b", outs(), {3'd7, 6'b100000});
        end
        step();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL dis_idle got=%b exp=%b", outs(), 9'b000_000000);
        end
    endtask

    // enable dropped during TX_SETUP: hold=3 completes, no tx_ack.
    task automatic test_abort_setup();
        guard_cycles = 16'd1; tx_setup_cycles = 16'd4; tx_hold_cycles = 16'd3;
        enable = 1'b1; rx_auto = 1'b0; tx_req = 1'b1;
        step();
        checks++;
        if (outs() !== {3'd3, 6'b100000}) begin
            failures++; $display("FAIL ab_guard got=%b exp=%b", outs(), {3'd3, 6'b100000});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs() !== {3'd4, 6'b101000}) begin
                failures++; $display("FAIL ab_setup%0d got=%b exp=%b", i, outs(), {3'd4, 6'b101000});
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== {3'd6, 6'b101000}) begin
                failures++; $display("FAIL ab_hold%0d got=%b exp=%b", i, outs(), {3'd6, 6'b101000});
            end
        end
        step();
        checks++;
        if (outs() !== {3'd7, 6'b100000}) begin
            failures++; $display("FAIL ab_guard_tr got=%b exp=%b", outs(), {3'd7, 6'b100000});
        end
        step();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL ab_idle got=%b exp=%b", outs(), 9'b000_000000);
        end
        tx_req = 1'b0;
    endtask

    // Async reset while transmitting clears outputs without a clock edge.
    task automatic test_async_reset();
        guard_cycles = '0; tx_setup_cycles = '0; tx_hold_cycles = 16'd7;
        enable = 1'b1; tx_req = 1'b1;
        repeat (3) step();
        checks++;
        if (outs() !== {3'd5, 6'b101011}) begin
            failures++; $display("FAIL ar_in_tx got=%b exp=%b", outs(), {3'd5, 6'b101011});
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL ar_async_clear got=%b exp=%b", outs(), 9'b000_000000);
        end
        enable = 1'b0; tx_req = 1'b0;
        step();
        rstn = 1'b1;
        prev_rx = 1'b0;
        prev_tx = 1'b0;
        step();
        checks++;
        if (outs() !== 9'b000_000000) begin
            failures++; $display("FAIL ar_after_release got=%b exp=%b", outs(), 9'b000_000000);
        end
    endtask

    // Random control traffic; exclusion is checked in every step.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 37 == 0) begin
                guard_cycles    = CNT_W'($urandom_range(0, 3));
                rx_setup_cycles = CNT_W'($urandom_range(0, 3));
                tx_setup_cycles = CNT_W'($urandom_range(0, 3));
                tx_hold_cycles  = CNT_W'($urandom_range(0, 3));
            end
            enable  = ($urandom_range(0, 15) != 0);
            rx_auto = ($urandom_range(0, 3) != 0);
            tx_req  = ($urandom_range(0, 2) == 0);
            tx_done = ($urandom_range(0, 5) == 0);
            step();
            checks++;
            if (busy !== (state != 3'd0)) begin
                failures++; $display("FAIL rnd_busy got=%0b state=%0d exp=%0b", busy, state, state != 3'd0);
            end
        end
        enable = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rx_setup();
        test_rx_to_tx();
        test_tx_to_rx();
        test_back_to_back();
        do_reset();
        test_abort_setup();
        test_async_reset();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
